// File: rtl/vga_frame_capture_if.sv
// Signal bundle between a VGA source, the frame capture block and the frame
// buffer write port. The capture block is the master of the write port and
// the consumer of the VGA stream.
interface vga_frame_capture_if;
    logic        VGA_HS;
    logic        VGA_VS;
    logic [7:0]  VGA_COLOUR;
    logic        WR_EN;
    logic [14:0] WR_ADDR;
    logic        WR_DATA;

    modport master (
        input  VGA_HS, VGA_VS, VGA_COLOUR,
        output WR_EN, WR_ADDR, WR_DATA
    );

    modport slave (
        output VGA_HS, VGA_VS, VGA_COLOUR,
        input  WR_EN, WR_ADDR, WR_DATA
    );
endinterface

// File: rtl/vga_frame_capture.sv
// VGA frame capture: recovers raster position from HS/VS falling edges,
// verifies line and frame length, and writes a 1-bit image at 1/4 resolution
// into the frame buffer using the {y[8:2], x[9:2]} address map.
// Optional build macro VGA_CAP_SYNC_EN adds a two-flop synchronizer on the
// VGA inputs for asynchronous sources (all outputs then lag by 2 CLK).
module vga_frame_capture #(
    parameter int HTs    = 800,
    parameter int HTpw   = 96,
    parameter int Hbp    = 48,
    parameter int HTDisp = 640,
    parameter int VTs    = 521,
    parameter int VTpw   = 2,
    parameter int Vbp    = 29,
    parameter int VTDisp = 480
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic [15:0]                CONFIG_COLOURS,
    vga_frame_capture_if.master        bus,
    output logic                       LOCKED,
    output logic                       ERR,
    output logic                       FRAME_DONE
);

    localparam logic [9:0]  H_FIRST   = 10'(HTpw + Hbp);
    localparam logic [9:0]  H_LAST    = 10'(HTpw + Hbp + HTDisp - 1);
    localparam logic [9:0]  V_FIRST   = 10'(VTpw + Vbp);
    localparam logic [9:0]  V_LAST    = 10'(VTpw + Vbp + VTDisp - 1);
    localparam logic [10:0] LINE_END  = 11'(2 * HTs - 1);
    localparam logic [9:0]  FRAME_END = 10'(VTs - 1);
    localparam logic [14:0] LAST_ADDR = {7'(VTDisp / 4 - 1), 8'(HTDisp / 4 - 1)};

    typedef enum logic [1:0] {
        ST_SEARCH,
        ST_MEASURE,
        ST_LOCKED
    } state_t;

    logic        w_hs_in;
    logic        w_vs_in;
    logic [7:0]  w_col_in;

`ifdef VGA_CAP_SYNC_EN
    logic        r_hs_s1, r_hs_s2;
    logic        r_vs_s1, r_vs_s2;
    logic [7:0]  r_col_s1, r_col_s2;

    // Two-flop synchronizer for an asynchronous VGA source; idle levels on reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_hs_s1  <= 1'b1;
            r_hs_s2  <= 1'b1;
            r_vs_s1  <= 1'b1;
            r_vs_s2  <= 1'b1;
            r_col_s1 <= 8'h00;
            r_col_s2 <= 8'h00;
        end else begin
            r_hs_s1  <= bus.VGA_HS;
            r_hs_s2  <= r_hs_s1;
            r_vs_s1  <= bus.VGA_VS;
            r_vs_s2  <= r_vs_s1;
            r_col_s1 <= bus.VGA_COLOUR;
            r_col_s2 <= r_col_s1;
        end
    end

    assign w_hs_in  = r_hs_s2;
    assign w_vs_in  = r_vs_s2;
    assign w_col_in = r_col_s2;
`else
    assign w_hs_in  = bus.VGA_HS;
    assign w_vs_in  = bus.VGA_VS;
    assign w_col_in = bus.VGA_COLOUR;
`endif

    logic        r_hs_q;
    logic        r_vs_q;
    logic [7:0]  r_col_q;
    logic [10:0] r_hcount;
    logic [9:0]  r_vcount;
    logic        r_vs_pend;

    // Edge registers: previous sync levels and the colour aligned with HCount.
    // NOTE: every clocked assignment is non-blocking so all flops see the
    // pre-edge values of each other, regardless of statement order.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_hs_q  <= 1'b1;
            r_vs_q  <= 1'b1;
            r_col_q <= 8'h00;
        end else begin
            r_hs_q  <= w_hs_in;
            r_vs_q  <= w_vs_in;
            r_col_q <= w_col_in;
        end
    end

    logic w_hs_fall;
    logic w_vs_fall;
    logic w_frame_zero;

    assign w_hs_fall    = r_hs_q & ~w_hs_in;
    assign w_vs_fall    = r_vs_q & ~w_vs_in;
    assign w_frame_zero = w_hs_fall & (r_vs_pend | w_vs_fall);

    // Horizontal position in CLK units, restarted by every HS fall.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_hcount <= '0;
        end else if (w_hs_fall) begin
            r_hcount <= '0;
        end else if (r_hcount != 11'h7FF) begin
            r_hcount <= r_hcount + 11'd1;
        end
    end

    // Line counter plus the VS-seen flag that turns the next HS fall into frame zero.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_vcount  <= '0;
            r_vs_pend <= 1'b0;
        end else begin
            if (w_frame_zero) begin
                r_vs_pend <= 1'b0;
            end else if (w_vs_fall) begin
                r_vs_pend <= 1'b1;
            end
            if (w_hs_fall) begin
                if (w_frame_zero) begin
                    r_vcount <= '0;
                end else if (r_vcount != 10'h3FF) begin
                    r_vcount <= r_vcount + 10'd1;
                end
            end
        end
    end

    logic [9:0]  w_hpix;
    logic [9:0]  w_x;
    logic [9:0]  w_y;
    logic        w_h_act;
    logic        w_v_act;
    logic        w_sample;
    logic [14:0] w_addr;
    logic        w_fg;
    logic        w_line_bad;
    logic        w_frame_bad;
    logic        w_viol;

    assign w_hpix   = r_hcount[10:1];
    assign w_x      = w_hpix - H_FIRST;
    assign w_y      = r_vcount - V_FIRST;
    assign w_h_act  = (w_hpix >= H_FIRST) && (w_hpix <= H_LAST);
    assign w_v_act  = (r_vcount >= V_FIRST) && (r_vcount <= V_LAST);
    // Second CLK of every 4th pixel on every 4th line: colour is stable there.
    assign w_sample = r_hcount[0] & w_h_act & w_v_act
                    & (w_x[1:0] == 2'b00) & (w_y[1:0] == 2'b00);
    assign w_addr   = {w_y[8:2], w_x[9:2]};
    assign w_fg     = (r_col_q == CONFIG_COLOURS[15:8]);

    assign w_line_bad  = w_hs_fall & (r_hcount != LINE_END);
    assign w_frame_bad = w_frame_zero & (r_vcount != FRAME_END);
    assign w_viol      = w_line_bad | w_frame_bad;

    // Background colour is not needed: anything but the foreground writes 0.
    logic w_unused;
    assign w_unused = ^{CONFIG_COLOURS[7:0], w_y[9]};

    state_t      r_state;
    logic        r_meas_bad;
    logic        r_locked;
    logic        r_err;
    logic        r_wr_en;
    logic [14:0] r_wr_addr;
    logic        r_wr_data;
    logic        r_frame_done;

    // Lock FSM with registered outputs: SEARCH for a frame, MEASURE one clean
    // frame, then write samples while LOCKED until a timing violation.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state      <= ST_SEARCH;
            r_meas_bad   <= 1'b0;
            r_locked     <= 1'b0;
            r_err        <= 1'b0;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_err        <= 1'b0;
            r_wr_en      <= 1'b0;
            r_frame_done <= 1'b0;
            case (r_state)
                ST_SEARCH: begin
                    if (w_frame_zero) begin
                        r_state    <= ST_MEASURE;
                        r_meas_bad <= 1'b0;
                    end
                end
                ST_MEASURE: begin
                    r_err <= w_viol;
                    if (w_frame_zero) begin
                        // A frame zero both closes one measurement and opens the next.
                        if (w_viol || r_meas_bad) begin
                            r_meas_bad <= 1'b0;
                        end else begin
                            r_state  <= ST_LOCKED;
                            r_locked <= 1'b1;
                        end
                    end else if (w_viol) begin
                        r_meas_bad <= 1'b1;
                    end
                end
                ST_LOCKED: begin
                    if (w_viol) begin
                        r_err    <= 1'b1;
                        r_locked <= 1'b0;
                        r_state  <= ST_SEARCH;
                    end else if (w_sample) begin
                        r_wr_en      <= 1'b1;
                        r_wr_addr    <= w_addr;
                        r_wr_data    <= w_fg;
                        r_frame_done <= (w_addr == LAST_ADDR);
                    end
                end
                default: begin
                    r_state  <= ST_SEARCH;
                    r_locked <= 1'b0;
                end
            endcase
        end
    end

    assign bus.WR_EN   = r_wr_en;
    assign bus.WR_ADDR = r_wr_addr;
    assign bus.WR_DATA = r_wr_data;
    assign LOCKED      = r_locked;
    assign ERR         = r_err;
    assign FRAME_DONE  = r_frame_done;

endmodule

// File: tb/tb_vga_frame_capture.sv
// Scoreboard bench for vga_frame_capture on a reduced raster (64x40 pixel
// periods, 40x32 active) so a full lock / error / relock sequence stays short.
// Expected writes are queued as pixels are driven and popped on WR_EN.
module tb_vga_frame_capture;

    localparam int HTS    = 64;
    localparam int HTPW   = 8;
    localparam int HBP    = 8;
    localparam int HTDISP = 40;
    localparam int VTS    = 40;
    localparam int VTPW   = 2;
    localparam int VBP    = 3;
    localparam int VTDISP = 32;
    localparam int HOFF   = HTPW + HBP;
    localparam int VOFF   = VTPW + VBP;
    localparam logic [14:0] LAST_ADDR = 15'h0709;  // y=7, x=9 in block units
`ifdef VGA_CAP_SYNC_EN
    localparam int OFF = 2;
`else
    localparam int OFF = 0;
`endif

    logic        CLK = 1'b0;
    logic        RESET;
    logic [15:0] CONFIG_COLOURS;
    logic        LOCKED;
    logic        ERR;
    logic        FRAME_DONE;

    vga_frame_capture_if bus();

    vga_frame_capture #(
        .HTs(HTS), .HTpw(HTPW), .Hbp(HBP), .HTDisp(HTDISP),
        .VTs(VTS), .VTpw(VTPW), .Vbp(VBP), .VTDisp(VTDISP)
    ) dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .CONFIG_COLOURS (CONFIG_COLOURS),
        .bus            (bus),
        .LOCKED         (LOCKED),
        .ERR            (ERR),
        .FRAME_DONE     (FRAME_DONE)
    );

    always #5 CLK = ~CLK;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          err_cnt  = 0;
    int          fd_cnt   = 0;
    int          wr_cnt   = 0;
    logic [16:0] sb_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // One CLK of stimulus; returns 1 time unit after the edge.
    task automatic cyc(input logic hs, input logic vs, input logic [7:0] col, input logic rst);
        bus.VGA_HS     = hs;
        bus.VGA_VS     = vs;
        bus.VGA_COLOUR = col;
        RESET          = rst;
        @(posedge CLK);
        #1;
    endtask

    // Drive lines start_line..n_lines-1 of a frame. pat 0: solid foreground,
    // pat 1: 4x4 checkerboard with non-foreground blocks in 8'h1C / 8'h00.
    // Writes are expected for lines below wr_lines.
    task automatic send_frame(input int start_line, input int n_lines, input int short_line,
                              input int rst_line, input int pat, input int wr_lines,
                              input logic exp_lock, input logic exp_err);
        for (int line = start_line; line < n_lines; line++) begin
            int len;
            len = (line == short_line) ? 2 * HTS - 2 : 2 * HTS;
            for (int c = 0; c < len; c++) begin
                int p, x, y;
                logic act, hs, vs, rst, d;
                logic [7:0] col;
                logic [14:0] a;
                p   = c / 2;
                x   = p - HOFF;
                y   = line - VOFF;
                hs  = (p >= HTPW);
                vs  = (line >= VTPW);
                act = (p >= HOFF) && (p < HOFF + HTDISP) && (line >= VOFF) && (line < VOFF + VTDISP);
                col = 8'h00;
                if (act) begin
                    if (pat == 0) col = 8'hFF;
                    else if ((((x >> 2) ^ (y >> 2)) & 1) == 1) col = 8'hFF;
                    else col = (((x >> 3) & 1) == 1) ? 8'h1C : 8'h00;
                end
                if (act && (c % 2 == 0) && (x % 4 == 0) && (y % 4 == 0) && (line < wr_lines)) begin
                    a = {7'(y / 4), 8'(x / 4)};
                    d = (pat == 0) ? 1'b1 : 1'(((x >> 2) ^ (y >> 2)) & 1);
                    sb_q.push_back({(a == LAST_ADDR), d, a});
                end
                rst = (line == rst_line) && (c >= 60) && (c < 63);
                cyc(hs, vs, col, rst);
                if (line == start_line && c == OFF) begin
                    check("lock_at_start", LOCKED, exp_lock);
                    check("err_at_start", ERR, exp_err);
                end
                if (exp_err && line == start_line && c == OFF + 1)
                    check("err_one_cycle", ERR, 1'b0);
                if (short_line >= 0 && line == short_line + 1 && c == OFF) begin
                    check("err_short_line", ERR, 1'b1);
                    check("lock_short_line", LOCKED, 1'b0);
                end
                if (short_line >= 0 && line == short_line + 1 && c == OFF + 1)
                    check("err_short_pulse", ERR, 1'b0);
                if (line == rst_line && c == 60)
                    check("outs_after_reset",
                          {bus.WR_EN, bus.WR_ADDR, bus.WR_DATA, LOCKED, ERR, FRAME_DONE}, 0);
            end
        end
    endtask

    logic [15:0] last_wr;
    logic        hold_pending = 1'b0;

    // Output monitor: pops the scoreboard on every write and checks hold behaviour.
    always @(negedge CLK) begin
        if (ERR) err_cnt++;
        if (FRAME_DONE) fd_cnt++;
        if (bus.WR_EN) begin
            wr_cnt++;
            if (sb_q.size() == 0) check("wr_unexpected", bus.WR_EN, 1'b0);
            else check("wr", {FRAME_DONE, bus.WR_DATA, bus.WR_ADDR}, sb_q.pop_front());
            last_wr      = {bus.WR_DATA, bus.WR_ADDR};
            hold_pending = 1'b1;
        end else begin
            if (hold_pending) check("wr_hold", {bus.WR_DATA, bus.WR_ADDR}, last_wr);
            hold_pending = 1'b0;
            if (FRAME_DONE) check("fd_without_wr", FRAME_DONE, 1'b0);
        end
    end

    initial begin
        CONFIG_COLOURS = 16'hFF00;
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 8'h00, 1'b1);
        check("reset_outs", {bus.WR_EN, bus.WR_ADDR, bus.WR_DATA, LOCKED, ERR, FRAME_DONE}, 0);

        // start_line, n_lines, short, rst, pat, wr_lines, exp_lock, exp_err
        send_frame(20, VTS,     -1, -1, 0, 0,   1'b0, 1'b0);  // partial frame, SEARCH
        send_frame(0,  VTS,     -1, -1, 0, 0,   1'b0, 1'b0);  // MEASURE
        send_frame(0,  VTS,     -1, -1, 0, VTS, 1'b1, 1'b0);  // locked, solid foreground
        send_frame(0,  VTS,     -1, -1, 1, VTS, 1'b1, 1'b0);  // checkerboard
        send_frame(0,  VTS,     20, -1, 1, 20,  1'b1, 1'b0);  // short line -> SEARCH
        send_frame(0,  VTS,     -1, -1, 1, 0,   1'b0, 1'b0);  // MEASURE
        send_frame(0,  VTS,     -1, 14, 0, 14,  1'b1, 1'b0);  // relocked, reset mid line
        send_frame(0,  VTS + 1, -1, -1, 0, 0,   1'b0, 1'b0);  // MEASURE, one line too many
        send_frame(0,  VTS,     -1, -1, 0, 0,   1'b0, 1'b1);  // frame error, re-MEASURE
        send_frame(0,  VTS,     -1, -1, 1, VTS, 1'b1, 1'b0);  // locked again
        send_frame(0,  2,       -1, -1, 0, 0,   1'b1, 1'b0);  // still locked

        check("sb_empty", sb_q.size(), 0);
        check("err_pulses", err_cnt, 2);
        check("frame_done_count", fd_cnt, 3);
        check("write_count", wr_cnt, 310);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vga_frame_capture.md
# vga_frame_capture

Receive-side counterpart of the VGA signal generator. Observes a VGA_HS/VGA_VS/VGA_COLOUR stream, recovers raster position from the sync edges, verifies timing, and writes a 160x120 1-bit image into the frame buffer's write port using the same {y[8:2], x[9:2]} address map the generator reads. Used for generator loopback self-test and for capturing external VGA sources at 50 MHz system clock (2 CLK per pixel).

## Interface
- HTs, 800: pixels per line
- HTpw, 96: HS pulse width, pixels
- Hbp, 48: horizontal back porch, pixels
- HTDisp, 640: active pixels per line
- VTs, 521: lines per frame
- VTpw, 2: VS pulse width, lines
- Vbp, 29: vertical back porch, lines
- VTDisp, 480: active lines per frame
- CLK  in  1  system clock, 50 MHz
- RESET  in  1  synchronous, active-high
- VGA_HS  in  1  horizontal sync, active-low
- VGA_VS  in  1  vertical sync, active-low
- VGA_COLOUR  in  8  pixel colour
- CONFIG_COLOURS  in  16  [15:8] foreground, [7:0] background
- WR_EN  out  1  frame buffer write strobe, one cycle
- WR_ADDR  out  15  {y[8:2], x[9:2]}
- WR_DATA  out  1  1 = pixel equals foreground
- LOCKED  out  1  timing verified, writes enabled
- ERR  out  1  one-cycle pulse on timing violation
- FRAME_DONE  out  1  one-cycle pulse with last write of a frame

## Operation
- Inputs registered once (HS_q, VS_q); HS fall = HS_q & ~VGA_HS; VS fall likewise.
- HCount (11 b, CLK units): 0 on HS fall, else +1, saturates at 2047. Pixel x = HCount[10:1] - (HTpw+Hbp); active when HCount[10:1] in [144, 783].
- VS fall sets vs_pend. At HS fall: if vs_pend (or VS fall same cycle) VCount <= 0, clear vs_pend ("frame zero"); else VCount +1, saturates at 1023. y = VCount - (VTpw+Vbp); active when VCount in [31, 510].
- Sample point: HCount[0]==1, x[1:0]==0, y[1:0]==0, both active. WR_DATA = (VGA_COLOUR == CONFIG_COLOURS[15:8]); any other colour (incl. background or neither) writes 0.
- Line check at every HS fall: HCount must equal 2*HTs-1 (1599). Frame check at frame zero: VCount must equal VTs-1 (520).
- FSM: SEARCH -> MEASURE at first frame zero. MEASURE: any violation -> ERR, restart MEASURE at next frame zero; frame zero with clean frame -> LOCKED. LOCKED: any violation -> ERR, SEARCH.
- WR_EN only in LOCKED. WR_ADDR/WR_DATA update only with WR_EN, else hold.
- FRAME_DONE asserted with the write to WR_ADDR 15'h779F (y=119, x=159).

## Timing
- Reset: WR_EN, WR_ADDR, WR_DATA, LOCKED, ERR, FRAME_DONE = 0; state SEARCH; HCount, VCount, vs_pend = 0.
- Sample at cycle t -> WR_EN/WR_ADDR/WR_DATA/FRAME_DONE valid at t+1, one cycle.
- ERR pulses cycle after offending HS fall; LOCKED falls same cycle; no WR_EN from that cycle on.
- LOCKED rises cycle after second clean frame zero; first writes occur in the frame starting there. Minimum lock time after reset: one partial + one full frame.
- 19200 writes per locked frame; one FRAME_DONE per frame.
- RESET mid-frame: immediate return to reset values, full relock required.

## Configuration
- VGA_CAP_SYNC_EN defined: two-flop synchronizer on VGA_HS, VGA_VS, VGA_COLOUR ahead of edge registers (asynchronous source); all outputs delayed 2 CLK, behaviour otherwise identical; synchronizer flops reset to HS=1, VS=1, COLOUR=0.
- Undefined: inputs assumed synchronous to CLK (loopback); no synchronizer.

## Test plan
- Nominal timing, all pixels = foreground 8'hFF, CONFIG 16'hFF00 -> LOCKED after second frame zero; next frame exactly 19200 WR_EN, all WR_DATA=1, FRAME_DONE once with WR_ADDR=15'h779F.
- Checkerboard by 4x4 block -> WR_DATA at {y[8:2],x[9:2]} = (x[2]^y[2]); colour 8'h1C written as 0.
- LOCKED, one line of 1598 CLK -> ERR pulse, LOCKED=0 next cycle, zero WR_EN until relock two frames later.
- MEASURE, frame of 522 lines -> ERR, LOCKED stays 0, locks after following clean frame.
- RESET for 3 cycles mid active line while LOCKED -> all outputs 0 next cycle, relock sequence repeats.
- VGA_CAP_SYNC_EN defined vs undefined, identical stimulus -> identical write sequence shifted +2 CLK.
